// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: WIDTH x DEPTH register file feeding a two-stage ALU pipe.
//   S1 captures the accepted instruction and its two operands.
//   S2 computes the result combinationally and writes it back at the next edge,
//   also presenting it on the res_* bus for one cycle.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
//   the requester holds every in_* field stable while in_valid && !in_ready.
// Optional feature macro: REGFILE_ALU_BYPASS_EN
//   defined   - S2 result is forwarded into operand capture, in_ready is always 1.
//   undefined - a source matching the in-flight destination stalls for one cycle.
module regfile_alu_pipe #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [1:0]       in_op,
  input  logic [AW-1:0]    in_src_a,
  input  logic [AW-1:0]    in_src_b,
  input  logic [AW-1:0]    in_dst,
  input  logic [WIDTH-1:0] ext_data,
  output logic             res_valid,
  output logic [AW-1:0]    res_dst,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // Architectural register file.
  logic [WIDTH-1:0] regs_q [DEPTH];

  // S1 operand register.
  logic             s1_valid_q;
  logic             s1_load_q;
  logic [1:0]       s1_op_q;
  logic [AW-1:0]    s1_dst_q;
  logic [WIDTH-1:0] s1_ext_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Write-back result register.
  logic             res_valid_q;
  logic [AW-1:0]    res_dst_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_cout_q;

  // S2 combinational result.
  logic [WIDTH-1:0] s2_result;
  logic             s2_cout;
  logic [WIDTH:0]   sum_ext;

  // Operand capture values and handshake.
  logic             hit_a;
  logic             hit_b;
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic             accept;

  // S2 execute: one extra bit on the adder holds the carry out of bit WIDTH-1.
  always_comb begin
    sum_ext   = '0;
    s2_result = '0;
    s2_cout   = 1'b0;
    if (s1_load_q) begin
      s2_result = s1_ext_q;
    end else begin
      case (s1_op_q)
        OP_ADD: begin
          sum_ext   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
          s2_result = sum_ext[WIDTH-1:0];
          s2_cout   = sum_ext[WIDTH];
        end
        OP_SUB: begin
          sum_ext   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};
          s2_result = sum_ext[WIDTH-1:0];
          s2_cout   = sum_ext[WIDTH];
        end
        OP_AND:  s2_result = s1_a_q & s1_b_q;
        default: s2_result = s1_a_q | s1_b_q;
      endcase
    end
  end

  // Hazard detection against the single in-flight instruction; only S1 can be
  // unwritten, anything older has already reached the file.
  always_comb begin
    hit_a = s1_valid_q && (in_src_a == s1_dst_q);
    hit_b = s1_valid_q && (in_src_b == s1_dst_q);
`ifdef REGFILE_ALU_BYPASS_EN
    opa_d    = hit_a ? s2_result : regs_q[in_src_a];
    opb_d    = hit_b ? s2_result : regs_q[in_src_b];
    in_ready = 1'b1;
`else
    opa_d    = regs_q[in_src_a];
    opb_d    = regs_q[in_src_b];
    in_ready = !(hit_a || hit_b);
`endif
  end

  assign accept = in_valid && in_ready;

  // S1 valid flag: set for exactly the cycle after an accept; reset drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
    end
  end

  // S1 payload: only meaningful while s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_load_q <= in_load;
      s1_op_q   <= in_op;
      s1_dst_q  <= in_dst;
      s1_ext_q  <= ext_data;
      s1_a_q    <= opa_d;
      s1_b_q    <= opb_d;
    end
  end

  // S2 write-back into the file and the one-cycle result pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      res_valid_q <= 1'b0;
      res_dst_q   <= '0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      res_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        regs_q[s1_dst_q] <= s2_result;
        res_dst_q        <= s1_dst_q;
        res_data_q       <= s2_result;
        res_cout_q       <= s2_cout;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_dst   = res_dst_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;

  // Debug port shows the file only; in-flight results are not visible here.
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Bench for regfile_alu_pipe: sequential-semantics model plus directed tests,
// plus two extra instances exercising other WIDTH/DEPTH parameterisations.
module tb_regfile_alu_pipe;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;
`ifdef REGFILE_ALU_BYPASS_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic          in_valid, in_ready, in_load;
  logic [1:0]    in_op;
  logic [AW-1:0] in_src_a, in_src_b, in_dst, dbg_addr, res_dst;
  logic [W-1:0]  ext_data, res_data, dbg_data;
  logic          res_valid, res_cout;

  regfile_alu_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_op(in_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_dst(in_dst), .ext_data(ext_data), .res_valid(res_valid), .res_dst(res_dst),
    .res_data(res_data), .res_cout(res_cout), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- sweep DUTs (8x4 and 32x16) ----------------
  logic        sw_valid, sw_load;
  logic [1:0]  sw_op;
  logic [3:0]  sw_a, sw_b, sw_dst, sw_dbg;
  logic [31:0] sw_data;
  logic        r8_ready, r8_rv, r8_cout;
  logic [1:0]  r8_dst;
  logic [7:0]  r8_data, r8_dbg;
  logic        r32_ready, r32_rv, r32_cout;
  logic [3:0]  r32_dst;
  logic [31:0] r32_data, r32_dbg;

  regfile_alu_pipe #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r8_ready),
    .in_load(sw_load), .in_op(sw_op), .in_src_a(sw_a[1:0]), .in_src_b(sw_b[1:0]),
    .in_dst(sw_dst[1:0]), .ext_data(sw_data[7:0]), .res_valid(r8_rv), .res_dst(r8_dst),
    .res_data(r8_data), .res_cout(r8_cout), .dbg_addr(sw_dbg[1:0]), .dbg_data(r8_dbg)
  );

  regfile_alu_pipe #(.WIDTH(32), .DEPTH(16)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(r32_ready),
    .in_load(sw_load), .in_op(sw_op), .in_src_a(sw_a), .in_src_b(sw_b),
    .in_dst(sw_dst), .ext_data(sw_data), .res_valid(r32_rv), .res_dst(r32_dst),
    .res_data(r32_data), .res_cout(r32_cout), .dbg_addr(sw_dbg), .dbg_data(r32_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [W-1:0]  data;
    logic          cout;
  } res_t;

  res_t         exp_q[$];      // accepted but not yet written back
  logic [W-1:0] arch_rf [D];   // state after every accepted instruction
  logic [W-1:0] file_rf [D];   // state the file must show right now
  res_t         exp_res;
  logic         exp_rv  = 1'b0;
  logic         exp_rst = 1'b0;
  logic         live    = 1'b0;
  int           run     = 0;
  int           max_run = 0;

  // Instruction semantics from plain integer arithmetic.
  function automatic res_t exec(input logic ld, input logic [1:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [AW-1:0] dst, input logic [W-1:0] ext);
    longint unsigned av = a;
    longint unsigned bv = b;
    longint unsigned m  = 64'd1 << W;
    res_t r;
    r.dst  = dst;
    r.cout = 1'b0;
    r.data = '0;
    if (ld) r.data = ext;
    else begin
      case (op)
        2'd0: begin r.data = W'((av + bv) % m); r.cout = ((av + bv) >= m); end
        2'd1: begin r.data = W'((av + m - bv) % m); r.cout = (av >= bv); end
        2'd2: r.data = a & b;
        default: r.data = a | b;
      endcase
    end
    return r;
  endfunction

  // Acceptance rule: only the one instruction still in flight can block.
  function automatic logic ready_model();
`ifdef REGFILE_ALU_BYPASS_EN
    return 1'b1;
`else
    if (exp_q.size() == 0) return 1'b1;
    return !((in_src_a == exp_q[0].dst) || (in_src_b == exp_q[0].dst));
`endif
  endfunction

  // Model advance on every rising edge.
  always @(posedge clk) begin
    logic rdy;
    res_t r;
    live <= 1'b1;
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < D; i++) begin arch_rf[i] = '0; file_rf[i] = '0; end
      exp_rv  = 1'b0;
      exp_rst = 1'b1;
    end else begin
      rdy     = ready_model();
      exp_rst = 1'b0;
      if (exp_q.size() > 0) begin
        exp_res = exp_q.pop_front();
        exp_rv  = 1'b1;
        file_rf[exp_res.dst] = exp_res.data;
      end else begin
        exp_rv = 1'b0;
      end
      if (in_valid && rdy) begin
        r = exec(in_load, in_op, arch_rf[in_src_a], arch_rf[in_src_b], in_dst, ext_data);
        arch_rf[in_dst] = r.data;
        exp_q.push_back(r);
      end
    end
  end

  // Compare process: every cycle, mid-cycle.
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", in_ready, ready_model());
      if (exp_rst) begin
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_dst", res_dst, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_cout", res_cout, 0);
      end else begin
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
          chk("res_dst", res_dst, exp_res.dst);
          chk("res_data", res_data, exp_res.data);
          chk("res_cout", res_cout, exp_res.cout);
        end
      end
      chk("dbg_data", dbg_data, file_rf[dbg_addr]);
      if (res_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic ld, input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [AW-1:0] b, input logic [AW-1:0] dst,
                      input logic [W-1:0] data, output int stalls);
    logic acc;
    acc      = 1'b0;
    stalls   = 0;
    in_valid = 1'b1; in_load = ld; in_op = op;
    in_src_a = a; in_src_b = b; in_dst = dst; ext_data = data;
    dbg_addr = dst;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string name, input logic [AW-1:0] dst,
                           input logic [W-1:0] data, input logic cout);
    @(posedge clk);
    #2;
    chk({name, "_valid"}, res_valid, 1);
    chk({name, "_dst"}, res_dst, dst);
    chk({name, "_data"}, res_data, data);
    chk({name, "_cout"}, res_cout, cout);
  endtask

  task automatic peek(input string name, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    dbg_addr = addr;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic sw_step(input logic ld, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] dst, input logic [31:0] data);
    sw_valid = 1'b1; sw_load = ld; sw_op = op;
    sw_a = a; sw_b = b; sw_dst = dst; sw_data = data;
    @(negedge clk);
    chk("sw8_ready", r8_ready, 1);
    chk("sw32_ready", r32_ready, 1);
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int st;
    int tot;
    reset = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_op = '0;
    in_src_a = '0; in_src_b = '0; in_dst = '0; ext_data = '0; dbg_addr = '0;
    sw_valid = 1'b0; sw_load = 1'b0; sw_op = '0;
    sw_a = '0; sw_b = '0; sw_dst = '0; sw_data = '0; sw_dbg = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_dbg", dbg_data, 0);

    // LOAD R1=5, LOAD R2=3, ADD R3
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 16'h0005, st); idle(1);
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd2, 16'h0003, st); idle(1);
    send(1'b0, 2'd0, 3'd1, 3'd2, 3'd3, 16'h0000, st);
    check_res("add_simple", 3'd3, 16'h0008, 1'b0);
    peek("dbg_r3", 3'd3, 16'h0008);

    // carry and borrow
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 16'hFFFF, st); idle(1);
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd2, 16'h0001, st); idle(1);
    send(1'b0, 2'd0, 3'd1, 3'd2, 3'd4, 16'h0000, st);
    check_res("add_carry", 3'd4, 16'h0000, 1'b1);
    send(1'b0, 2'd1, 3'd2, 3'd1, 3'd5, 16'h0000, st);
    check_res("sub_borrow", 3'd5, 16'h0002, 1'b0);

    // dependent back-to-back pair
    idle(1);
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 16'h00F0, st);
    chk("hazard_load_stalls", st, 0);
    send(1'b0, 2'd0, 3'd1, 3'd1, 3'd2, 16'h0000, st);
    chk("hazard_stalls", st, EXP_STALL);
    check_res("hazard_add", 3'd2, 16'h01E0, 1'b0);
    idle(1);

    // continuous stream of independent loads
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 2'd0, 3'(i), 3'(i), 3'(i), 16'(16'h1000 + i * 16'h0111), st);
      tot += st;
    end
    chk("stream_stalls", tot, 0);
    idle(2);
    chk("stream_run", max_run, 8);
    for (int i = 0; i < 8; i++) peek("stream_dbg", 3'(i), 16'(16'h1000 + i * 16'h0111));

    // reset with R6 load sitting in S1
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd6, 16'h1234, st);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_drop_valid", res_valid, 0);
      chk("rst_drop_ready", in_ready, 1);
      idle(1);
    end
    peek("rst_r6", 3'd6, 16'h0000);
    peek("rst_r7", 3'd7, 16'h0000);

    // AND / OR
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 16'hAAAA, st); idle(1);
    send(1'b1, 2'd0, 3'd0, 3'd0, 3'd2, 16'h0FF0, st); idle(1);
    send(1'b0, 2'd2, 3'd1, 3'd2, 3'd3, 16'h0000, st);
    check_res("and", 3'd3, 16'h0AA0, 1'b0);
    send(1'b0, 2'd3, 3'd1, 3'd2, 3'd4, 16'h0000, st);
    check_res("or", 3'd4, 16'hAFFA, 1'b0);
    idle(2);

    // parameter sweep: ADD carry case on 8x4 and 32x16
    sw_step(1'b1, 2'd0, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF); idle(1);
    sw_step(1'b1, 2'd0, 4'd0, 4'd0, 4'd2, 32'h0000_0001); idle(1);
    sw_step(1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 32'h0000_0000);
    @(posedge clk);
    #2;
    chk("sw8_valid", r8_rv, 1);
    chk("sw8_dst", r8_dst, 3);
    chk("sw8_data", r8_data, 8'h00);
    chk("sw8_cout", r8_cout, 1);
    chk("sw32_valid", r32_rv, 1);
    chk("sw32_dst", r32_dst, 4'd3);
    chk("sw32_data", r32_data, 32'h0);
    chk("sw32_cout", r32_cout, 1);
    sw_dbg = 4'd1;
    #1;
    chk("sw8_dbg_r1", r8_dbg, 8'hFF);
    chk("sw32_dbg_r1", r32_dbg, 32'hFFFF_FFFF);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
